cnn_result_serializer: RTL and testbench

//  Receives one frame of parallel convolution results from the CNN comparator core:
//   2 channels x 4 signed outputs (OR1_0..3, OR2_0..3).

---
 rtl/cnn_result_serializer.sv | 151 +++++++++++++++
 tb/tb_cnn_result_serializer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_result_serializer.sv
// Frame serializer for the CNN comparator core: buffers 2x4 signed results
// and streams them one word per handshake, each channel followed by its max.
module cnn_result_serializer #(
    parameter int DW   = 12,
    parameter bit RELU = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] or1_0,
    input  logic [DW-1:0] or1_1,
    input  logic [DW-1:0] or1_2,
    input  logic [DW-1:0] or1_3,
    input  logic [DW-1:0] or2_0,
    input  logic [DW-1:0] or2_1,
    input  logic [DW-1:0] or2_2,
    input  logic [DW-1:0] or2_3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_tag,
    output logic          out_ch,
    output logic          out_last,
    output logic [7:0]    frame_cnt
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic signed [DW-1:0] buf_q [8];
    logic signed [DW-1:0] buf_d [8];
    logic signed [DW-1:0] max_q, max_d;
    logic signed [DW-1:0] pool;
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] out_data_q, out_data_d;
    logic [2:0]           out_tag_q, out_tag_d;
    logic                 out_ch_q, out_ch_d;
    logic                 out_last_q, out_last_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic                 xfer;
    logic [1:0]           nxt_tag;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;

    assign xfer    = out_valid_q && out_ready;
    assign nxt_tag = out_tag_q[1:0] + 2'd1;

    always_comb begin
        max_d = max_q;
        if (xfer) begin
            if (out_tag_q == 3'd0) begin
                max_d = out_data_q;
            end else if (out_tag_q != 3'd4 && out_data_q > max_q) begin
                max_d = out_data_q;
            end
        end
        pool = (RELU && max_d[DW-1]) ? '0 : max_d;
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d[0]    = or1_0;
                    buf_d[1]    = or1_1;
                    buf_d[2]    = or1_2;
                    buf_d[3]    = or1_3;
                    buf_d[4]    = or2_0;
                    buf_d[5]    = or2_1;
                    buf_d[6]    = or2_2;
                    buf_d[7]    = or2_3;
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                    out_data_d  = or1_0;
                    out_tag_d   = 3'd0;
                    out_ch_d    = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (out_tag_q == 3'd4) begin
                        if (out_ch_q) begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end else begin
                            out_ch_d   = 1'b1;
                            out_tag_d  = 3'd0;
                            out_data_d = buf_q[4];
                        end
                    end else if (out_tag_q == 3'd3) begin
                        // pooled word carries the max including this transfer
                        out_tag_d  = 3'd4;
                        out_data_d = pool;
                        out_last_d = out_ch_q;
                    end else begin
                        out_tag_d  = {1'b0, nxt_tag};
                        out_data_d = buf_q[{out_ch_q, nxt_tag}];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= 3'd0;
            out_ch_q    <= 1'b0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_cnn_result_serializer.sv
// Directed bench for cnn_result_serializer: one instance per RELU setting,
// both fed identical stimulus.
module tb_cnn_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [11:0] or1_0, or1_1, or1_2, or1_3;
    logic [11:0] or2_0, or2_1, or2_2, or2_3;

    logic        in_ready, out_valid, out_ch, out_last;
    logic [11:0] out_data;
    logic [2:0]  out_tag;
    logic [7:0]  frame_cnt;

    logic        in_ready1, out_valid1, out_ch1, out_last1;
    logic [11:0] out_data1;
    logic [2:0]  out_tag1;
    logic [7:0]  frame_cnt1;

    int checks = 0;
    int errors = 0;
    int fcnt   = 0;

    always #5 clk = ~clk;

    cnn_result_serializer #(.DW(12), .RELU(1'b0)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .or1_0(or1_0), .or1_1(or1_1), .or1_2(or1_2), .or1_3(or1_3),
        .or2_0(or2_0), .or2_1(or2_1), .or2_2(or2_2), .or2_3(or2_3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_ch(out_ch),
        .out_last(out_last), .frame_cnt(frame_cnt)
    );

    cnn_result_serializer #(.DW(12), .RELU(1'b1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1),
        .or1_0(or1_0), .or1_1(or1_1), .or1_2(or1_2), .or1_3(or1_3),
        .or2_0(or2_0), .or2_1(or2_1), .or2_2(or2_2), .or2_3(or2_3),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_tag(out_tag1), .out_ch(out_ch1),
        .out_last(out_last1), .frame_cnt(frame_cnt1)
    );

    task automatic set_in(input int a0, a1, a2, a3, b0, b1, b2, b3);
        or1_0 = 12'(a0); or1_1 = 12'(a1); or1_2 = 12'(a2); or1_3 = 12'(a3);
        or2_0 = 12'(b0); or2_1 = 12'(b1); or2_2 = 12'(b2); or2_3 = 12'(b3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // waits (bounded) for in_ready, then presents one capture cycle
    task automatic start_frame();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_word(output logic [11:0] d0, output logic [11:0] d1,
                            output logic [2:0] tg, output logic c,
                            output logic l, output bit ok);
        ok = 1'b0; d0 = '0; d1 = '0; tg = '0; c = 1'b0; l = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (out_valid && out_ready) begin
                d0 = out_data; d1 = out_data1;
                tg = out_tag; c = out_ch; l = out_last;
                ok = 1'b1;
            end
            tick();
        end
    endtask

    task automatic check_frame(input string nm, input int e0[10],
                               input int e1[10], input int first);
        logic [11:0] d0, d1;
        logic [2:0]  tg;
        logic        c, l;
        bit          ok;
        for (int i = first; i < 10; i++) begin
            get_word(d0, d1, tg, c, l, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s timeout word %0d", nm, i);
            end
            checks++;
            if (d0 !== 12'(e0[i])) begin
                errors++;
                $display("FAIL %s data w%0d got %0d exp %0d",
                         nm, i, $signed(d0), e0[i]);
            end
            checks++;
            if (d1 !== 12'(e1[i])) begin
                errors++;
                $display("FAIL %s relu data w%0d got %0d exp %0d",
                         nm, i, $signed(d1), e1[i]);
            end
            checks++;
            if (tg !== 3'(i % 5) || c !== (i >= 5) || l !== (i == 9)) begin
                errors++;
                $display("FAIL %s tag/ch/last w%0d got %0d/%0d/%0d exp %0d/%0d/%0d",
                         nm, i, tg, c, l, i % 5, i >= 5, i == 9);
            end
        end
        fcnt = (fcnt + 1) % 256;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end valid/ready got %0d/%0d exp 0/1",
                     nm, out_valid, in_ready);
        end
        checks++;
        if (frame_cnt !== 8'(fcnt) || frame_cnt1 !== 8'(fcnt)) begin
            errors++;
            $display("FAIL %s frame_cnt got %0d/%0d exp %0d",
                     nm, frame_cnt, frame_cnt1, fcnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 0 || in_ready !== 0 || frame_cnt !== 0 ||
            out_data !== 0 || out_tag !== 0 || out_ch !== 0 || out_last !== 0) begin
            errors++;
            $display("FAIL reset u0 v=%0d r=%0d c=%0d d=%0d t=%0d ch=%0d l=%0d exp all 0",
                     out_valid, in_ready, frame_cnt, out_data, out_tag, out_ch, out_last);
        end
        checks++;
        if (out_valid1 !== 0 || in_ready1 !== 0 || frame_cnt1 !== 0 ||
            out_data1 !== 0 || out_tag1 !== 0 || out_ch1 !== 0 || out_last1 !== 0) begin
            errors++;
            $display("FAIL reset u1 v=%0d r=%0d c=%0d d=%0d t=%0d ch=%0d l=%0d exp all 0",
                     out_valid1, in_ready1, frame_cnt1, out_data1, out_tag1,
                     out_ch1, out_last1);
        end
        rst = 1'b0;
        fcnt = 0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset release in_ready got %0d exp 1, out_valid got %0d exp 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_busy_reset();
        logic [11:0] d0, d1;
        logic [2:0]  tg;
        logic        c, l;
        bit          ok;
        int          e[4] = '{5, -3, 12, 7};
        int          e0[10] = '{20, 21, 22, 23, 23, -1, -5, 3, 3, 3};
        set_in(5, -3, 12, 7, -8, -2, -6, -4);
        start_frame();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                set_in(100, 101, 102, 103, 104, 105, 106, 107);
                in_valid = 1'b1;
            end
            get_word(d0, d1, tg, c, l, ok);
            in_valid = 1'b0;
            checks++;
            if (!ok || d0 !== 12'(e[i]) || tg !== 3'(i)) begin
                errors++;
                $display("FAIL busy word%0d got %0d tag %0d exp %0d tag %0d",
                         i, $signed(d0), tg, e[i], i);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 0 || in_ready !== 0 || out_data !== 0 ||
            out_tag !== 0 || frame_cnt !== 8'(fcnt)) begin
            errors++;
            $display("FAIL midreset v=%0d r=%0d d=%0d t=%0d cnt=%0d exp 0/0/0/0/%0d",
                     out_valid, in_ready, out_data, out_tag, frame_cnt, fcnt);
        end
        rst = 1'b0;
        set_in(20, 21, 22, 23, -1, -5, 3, 3);
        start_frame();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 3'd0 || out_ch !== 1'b0 ||
            out_data !== 12'd20) begin
            errors++;
            $display("FAIL restart v=%0d t=%0d ch=%0d d=%0d exp 1/0/0/20",
                     out_valid, out_tag, out_ch, out_data);
        end
        check_frame("restart", e0, e0, 0);
    endtask

    task automatic test_basic();
        int e0[10] = '{5, -3, 12, 7, 12, -8, -2, -6, -4, -2};
        int e1[10] = '{5, -3, 12, 7, 12, -8, -2, -6, -4, 0};
        set_in(5, -3, 12, 7, -8, -2, -6, -4);
        start_frame();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 12'd5) begin
            errors++;
            $display("FAIL latency out_valid %0d data %0d exp 1 5",
                     out_valid, $signed(out_data));
        end
        check_frame("basic", e0, e1, 0);
    endtask

    task automatic test_relu();
        int e1[10] = '{3, 1, 9, 2, 9, -1, -7, -3, -9, -1};
        int e2[10] = '{3, 1, 9, 2, 9, -1, -7, -3, -9, 0};
        set_in(3, 1, 9, 2, -1, -7, -3, -9);
        start_frame();
        check_frame("relu", e1, e2, 0);
    endtask

    task automatic test_backpressure();
        logic [11:0] d0, d1;
        logic [2:0]  tg;
        logic        c, l;
        bit          ok;
        int e0[10] = '{5, -3, 12, 7, 12, -8, -2, -6, -4, -2};
        int e1[10] = '{5, -3, 12, 7, 12, -8, -2, -6, -4, 0};
        set_in(5, -3, 12, 7, -8, -2, -6, -4);
        start_frame();
        for (int i = 0; i < 2; i++) begin
            get_word(d0, d1, tg, c, l, ok);
            checks++;
            if (!ok || d0 !== 12'(e0[i])) begin
                errors++;
                $display("FAIL bp pre w%0d got %0d exp %0d",
                         i, $signed(d0), e0[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 12'd12 ||
                out_tag !== 3'd2 || out_ch !== 1'b0) begin
                errors++;
                $display("FAIL bp hold cyc%0d v=%0d d=%0d t=%0d ch=%0d exp 1/12/2/0",
                         k, out_valid, $signed(out_data), out_tag, out_ch);
            end
            out_ready = (k == 3);
            if (k < 3) tick();
        end
        check_frame("bp", e0, e1, 2);
    endtask

    task automatic test_extremes();
        int a0[10] = '{-2048, -2048, -2048, -2048, -2048,
                       -2048, -2048, -2048, -2048, -2048};
        int a1[10] = '{-2048, -2048, -2048, -2048, 0,
                       -2048, -2048, -2048, -2048, 0};
        int b0[10] = '{-2048, -2048, -2048, 2047, 2047,
                       -2048, -2048, -2048, -2048, -2048};
        int b1[10] = '{-2048, -2048, -2048, 2047, 2047,
                       -2048, -2048, -2048, -2048, 0};
        set_in(-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048);
        start_frame();
        check_frame("ext_min", a0, a1, 0);
        set_in(-2048, -2048, -2048, 2047, -2048, -2048, -2048, -2048);
        start_frame();
        check_frame("ext_max", b0, b1, 0);
    endtask

    task automatic test_counter();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fcnt = 0;
        tick();
        set_in(1, 2, 3, 4, 5, 6, 7, 8);
        in_valid = 1'b1;
        for (int t = 0; t < 256 * 11; t++) begin
            checks++;
            if (in_ready !== (t % 11 == 0)) begin
                errors++;
                $display("FAIL cnt in_ready t=%0d got %0d exp %0d",
                         t, in_ready, t % 11 == 0);
            end
            if (t == 256 * 11 - 1) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL cnt pre-wrap got %0d exp 255", frame_cnt);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (frame_cnt !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL cnt wrap cnt=%0d v=%0d r=%0d exp 0/0/1",
                     frame_cnt, out_valid, in_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_busy_reset();
        test_basic();
        test_relu();
        test_backpressure();
        test_extremes();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
